// File: rtl/trap_sequencer_pkg.sv
// Shared definitions for the machine-mode trap/return sequencer:
// CSR addresses, cause codes, mstatus bit positions and the state encoding.
package trap_defs;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam logic [31:0] CAUSE_EXT_INT = 32'h8000_000B;
  localparam logic [31:0] CAUSE_ILLEGAL = 32'd2;
  localparam logic [31:0] CAUSE_ECALL   = 32'd11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  typedef enum logic [2:0] {
    IDLE,
    T_MEPC,
    T_MCAUSE,
    T_MTVAL,
    T_MSTATUS,
    T_JUMP,
    M_STATUS,
    M_JUMP
  } state_e;

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline-side and CSR-side signals of the trap sequencer; the sequencer
// itself uses the slave view, the pipeline/CSR environment the master view.
interface trap_sequencer_if #(parameter int XLEN = 32);

  logic            valid_mem;
  logic [1:0]      exp_vector_mem;
  logic            mret_mem;
  logic [XLEN-1:0] pc_mem;
  logic [31:0]     inst_mem;
  logic            ext_int;
  logic [11:0]     csr_raddr;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_we;
  logic [11:0]     csr_waddr;
  logic [XLEN-1:0] csr_wdata;
  logic            flush;
  logic            stall_if;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;

  modport slave (
    input  valid_mem, exp_vector_mem, mret_mem, pc_mem, inst_mem, ext_int, csr_rdata,
    output csr_raddr, csr_we, csr_waddr, csr_wdata, flush, stall_if,
           redirect_valid, redirect_pc
  );

  modport master (
    output valid_mem, exp_vector_mem, mret_mem, pc_mem, inst_mem, ext_int, csr_rdata,
    input  csr_raddr, csr_we, csr_waddr, csr_wdata, flush, stall_if,
           redirect_valid, redirect_pc
  );

endinterface

// File: rtl/trap_sequencer_cause_enc.sv
// Priority encoder for the MEM-stage instruction:
// interrupt > illegal > ecall > mret; bubbles never produce an event.
module trap_cause_enc
  import trap_defs::*;
#(
  parameter int XLEN = 32
) (
  input  logic            valid_i,
  input  logic [1:0]      exp_vector_i,
  input  logic            mret_i,
  input  logic            ext_int_i,
  input  logic            mie_i,
  input  logic [31:0]     inst_i,
  output logic            take_trap_o,
  output logic            take_mret_o,
  output logic [31:0]     cause_o,
  output logic [XLEN-1:0] tval_o
);

  always_comb begin
    take_trap_o = 1'b0;
    take_mret_o = 1'b0;
    cause_o     = '0;
    tval_o      = '0;
    if (valid_i) begin
      if (ext_int_i && mie_i) begin
        take_trap_o = 1'b1;
        cause_o     = CAUSE_EXT_INT;
      end else if (exp_vector_i[1]) begin
        take_trap_o = 1'b1;
        cause_o     = CAUSE_ILLEGAL;
        tval_o      = XLEN'(inst_i);
      end else if (exp_vector_i[0]) begin
        take_trap_o = 1'b1;
        cause_o     = CAUSE_ECALL;
      end else if (mret_i) begin
        take_mret_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/trap_sequencer.sv
// Machine-mode trap/MRET controller: flushes the pipeline, walks the single
// CSR write port through mepc/mcause/mtval/mstatus, then redirects fetch.
module trap_sequencer
  import trap_defs::*;
#(
  parameter int              XLEN                 = 32,
  parameter logic [XLEN-1:0] RESET_MTVEC_FALLBACK = '0
) (
  input logic           clk,
  input logic           rst,
  trap_sequencer_if.slave bus
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;

  logic            take_trap, take_mret;
  logic [31:0]     enc_cause;
  logic [XLEN-1:0] enc_tval;
  logic [XLEN-1:0] vec_base, vec_tgt;

  trap_cause_enc #(.XLEN(XLEN)) u_cause_enc (
    .valid_i      (bus.valid_mem),
    .exp_vector_i (bus.exp_vector_mem),
    .mret_i       (bus.mret_mem),
    .ext_int_i    (bus.ext_int),
    .mie_i        (bus.csr_rdata[MSTATUS_MIE]),
    .inst_i       (bus.inst_mem),
    .take_trap_o  (take_trap),
    .take_mret_o  (take_mret),
    .cause_o      (enc_cause),
    .tval_o       (enc_tval)
  );

  // Vectored mode only applies to interrupts; exceptions always use the base.
  assign vec_base = {bus.csr_rdata[XLEN-1:2], 2'b00};
  assign vec_tgt  = (bus.csr_rdata[1:0] == 2'b01 && cause_q[31])
                  ? vec_base + XLEN'({cause_q[30:0], 2'b00}) : vec_base;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cause_q <= '0;
      tval_q  <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cause_q <= cause_d;
      tval_q  <= tval_d;
    end
  end

  // Read address kept apart from the data path so it never depends on csr_rdata.
  always_comb begin
    bus.csr_raddr = '0;
    if (!rst) begin
      unique case (state_q)
        IDLE:      if (bus.valid_mem && bus.ext_int) bus.csr_raddr = CSR_MSTATUS;
        T_MSTATUS: bus.csr_raddr = CSR_MSTATUS;
        T_JUMP:    bus.csr_raddr = CSR_MTVEC;
        M_STATUS:  bus.csr_raddr = CSR_MSTATUS;
        M_JUMP:    bus.csr_raddr = CSR_MEPC;
        default:   bus.csr_raddr = '0;
      endcase
    end
  end

  always_comb begin
    state_d            = state_q;
    pc_d               = pc_q;
    cause_d            = cause_q;
    tval_d             = tval_q;
    bus.csr_we         = 1'b0;
    bus.csr_waddr      = '0;
    bus.csr_wdata      = '0;
    bus.flush          = 1'b0;
    bus.stall_if       = (state_q != IDLE);
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    unique case (state_q)
      IDLE: begin
        if (take_trap) begin
          bus.flush    = 1'b1;
          bus.stall_if = 1'b1;
          pc_d         = bus.pc_mem;
          cause_d      = enc_cause;
          tval_d       = enc_tval;
          state_d      = T_MEPC;
        end else if (take_mret) begin
          bus.flush    = 1'b1;
          bus.stall_if = 1'b1;
          state_d      = M_STATUS;
        end
      end
      T_MEPC: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MEPC;
        bus.csr_wdata = pc_q;
        state_d       = T_MCAUSE;
      end
      T_MCAUSE: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MCAUSE;
        bus.csr_wdata = XLEN'(cause_q);
        state_d       = T_MTVAL;
      end
      T_MTVAL: begin
        bus.csr_we    = 1'b1;
        bus.csr_waddr = CSR_MTVAL;
        bus.csr_wdata = tval_q;
        state_d       = T_MSTATUS;
      end
      T_MSTATUS: begin
        bus.csr_we                                     = 1'b1;
        bus.csr_waddr                                  = CSR_MSTATUS;
        bus.csr_wdata                                  = bus.csr_rdata;
        bus.csr_wdata[MSTATUS_MPIE]                    = bus.csr_rdata[MSTATUS_MIE];
        bus.csr_wdata[MSTATUS_MIE]                     = 1'b0;
        bus.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
        state_d                                        = T_JUMP;
      end
      T_JUMP: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = (vec_tgt == '0) ? RESET_MTVEC_FALLBACK : vec_tgt;
        state_d            = IDLE;
      end
      M_STATUS: begin
        bus.csr_we                                     = 1'b1;
        bus.csr_waddr                                  = CSR_MSTATUS;
        bus.csr_wdata                                  = bus.csr_rdata;
        bus.csr_wdata[MSTATUS_MIE]                     = bus.csr_rdata[MSTATUS_MPIE];
        bus.csr_wdata[MSTATUS_MPIE]                    = 1'b1;
        bus.csr_wdata[MSTATUS_MPP_HI:MSTATUS_MPP_LO]   = 2'b11;
        state_d                                        = M_JUMP;
      end
      M_JUMP: begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = {bus.csr_rdata[XLEN-1:2], 2'b00};
        state_d            = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset silences every output so an interrupted sequence commits nothing.
    if (rst) begin
      bus.csr_we         = 1'b0;
      bus.csr_waddr      = '0;
      bus.csr_wdata      = '0;
      bus.flush          = 1'b0;
      bus.stall_if       = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_pc    = '0;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: stimulus pushes expected CSR writes,
// redirects and per-cycle control values; one monitor pops and compares them.
module tb_trap_sequencer;

  localparam logic [31:0] FALLBACK = 32'h0000_0F00;

  typedef struct { int cyc; logic [11:0] addr; logic [31:0] data; } wrExp_t;
  typedef struct { int cyc; logic [31:0] pc; } rdExp_t;
  typedef struct {
    int cyc; logic [127:0] tag; logic flush; logic stall; logic chkQuiet; logic zeroAll;
  } ctrlExp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   dCyc = 0;
  int   checks = 0;
  int   failures = 0;
  logic done = 1'b0;

  logic        loadEn = 1'b0;
  logic [11:0] loadAddr = '0;
  logic [31:0] loadData = '0;
  logic [31:0] csrMem [0:4095];

  wrExp_t   wrQ[$];
  rdExp_t   rdQ[$];
  ctrlExp_t ctrlQ[$];
  wrExp_t   we_e;
  rdExp_t   rd_e;
  ctrlExp_t ce;
  logic [3:0] gotv, wantv, maskv;
  logic       bad;

  trap_sequencer_if #(.XLEN(32)) bus ();

  trap_sequencer #(.XLEN(32), .RESET_MTVEC_FALLBACK(FALLBACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Minimal CSR file: combinational read, write at the clock edge.
  assign bus.csr_rdata = csrMem[bus.csr_raddr];
  always @(posedge clk) begin
    if (loadEn) csrMem[loadAddr] <= loadData;
    else if (bus.csr_we) csrMem[bus.csr_waddr] <= bus.csr_wdata;
  end

  // Monitor: every comparison lives here, sampled on the falling edge.
  always @(negedge clk) begin
    while (ctrlQ.size() > 0 && ctrlQ[0].cyc <= cyc) begin
      ce = ctrlQ.pop_front();
      checks++;
      if (ce.cyc != cyc) begin
        failures++;
        $display("[TB] FAIL %0s ctrl check missed: got cyc=%0d want cyc=%0d", ce.tag, cyc, ce.cyc);
      end else begin
        gotv  = {bus.flush, bus.stall_if, bus.csr_we, bus.redirect_valid};
        wantv = {ce.flush, ce.stall, 2'b00};
        maskv = ce.chkQuiet ? 4'b1111 : 4'b1100;
        bad   = ((gotv ^ wantv) & maskv) != 4'b0000;
        if (ce.zeroAll && (bus.csr_raddr != 12'h0 || bus.csr_waddr != 12'h0 ||
                           bus.csr_wdata != 32'h0 || bus.redirect_pc != 32'h0)) bad = 1'b1;
        if (bad) begin
          failures++;
          $display("[TB] FAIL %0s cyc=%0d got flush,stall,we,rv=%b raddr=%h waddr=%h wdata=%h rpc=%h want %b mask=%b zero=%0d",
                   ce.tag, cyc, gotv, bus.csr_raddr, bus.csr_waddr, bus.csr_wdata,
                   bus.redirect_pc, wantv, maskv, ce.zeroAll);
        end
      end
    end

    if (bus.csr_we) begin
      checks++;
      if (wrQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL csr_write unexpected: got addr=%h data=%h cyc=%0d want no write",
                 bus.csr_waddr, bus.csr_wdata, cyc);
      end else begin
        we_e = wrQ.pop_front();
        if (bus.csr_waddr != we_e.addr || bus.csr_wdata != we_e.data || cyc != we_e.cyc) begin
          failures++;
          $display("[TB] FAIL csr_write: got addr=%h data=%h cyc=%0d want addr=%h data=%h cyc=%0d",
                   bus.csr_waddr, bus.csr_wdata, cyc, we_e.addr, we_e.data, we_e.cyc);
        end
      end
    end

    if (bus.redirect_valid) begin
      checks++;
      if (rdQ.size() == 0) begin
        failures++;
        $display("[TB] FAIL redirect unexpected: got pc=%h cyc=%0d want no redirect",
                 bus.redirect_pc, cyc);
      end else begin
        rd_e = rdQ.pop_front();
        if (bus.redirect_pc != rd_e.pc || cyc != rd_e.cyc) begin
          failures++;
          $display("[TB] FAIL redirect: got pc=%h cyc=%0d want pc=%h cyc=%0d",
                   bus.redirect_pc, cyc, rd_e.pc, rd_e.cyc);
        end
      end
    end

    if (done) begin
      checks++;
      if (wrQ.size() != 0) begin
        failures++;
        $display("[TB] FAIL pending_writes: got %0d outstanding want 0", wrQ.size());
      end
      checks++;
      if (rdQ.size() != 0 || ctrlQ.size() != 0) begin
        failures++;
        $display("[TB] FAIL pending_redirects: got rd=%0d ctrl=%0d outstanding want 0",
                 rdQ.size(), ctrlQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion want finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic v, input logic [1:0] ev, input logic m,
                               input logic ei, input logic [31:0] pc, input logic [31:0] inst);
    bus.valid_mem      = v;
    bus.exp_vector_mem = ev;
    bus.mret_mem       = m;
    bus.ext_int        = ei;
    bus.pc_mem         = pc;
    bus.inst_mem       = inst;
    dCyc               = cyc;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic checkOutput(input logic [127:0] tag, input int off, input logic f,
                             input logic s, input logic quiet, input logic zero);
    ctrlExp_t e;
    e.cyc = dCyc + off; e.tag = tag; e.flush = f; e.stall = s;
    e.chkQuiet = quiet; e.zeroAll = zero;
    ctrlQ.push_back(e);
  endtask

  task automatic expectWrite(input logic [11:0] a, input logic [31:0] d, input int off);
    wrExp_t e;
    e.cyc = dCyc + off; e.addr = a; e.data = d;
    wrQ.push_back(e);
  endtask

  task automatic expectRedirect(input logic [31:0] pc, input int off);
    rdExp_t e;
    e.cyc = dCyc + off; e.pc = pc;
    rdQ.push_back(e);
  endtask

  task automatic expectTrap(input logic [127:0] tag, input logic [31:0] pc, input logic [31:0] cause,
                            input logic [31:0] tval, input logic [31:0] mstat, input logic [31:0] tgt);
    checkOutput(tag, 0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int k = 1; k <= 5; k++) checkOutput(tag, k, 1'b0, 1'b1, 1'b0, 1'b0);
    expectWrite(12'h341, pc, 1);
    expectWrite(12'h342, cause, 2);
    expectWrite(12'h343, tval, 3);
    expectWrite(12'h300, mstat, 4);
    expectRedirect(tgt, 5);
  endtask

  task automatic waitCycles(input int n);
    @(posedge clk); #1;
    idleInputs();
    for (int k = 1; k < n; k++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic loadCsr(input logic [11:0] a, input logic [31:0] d);
    loadEn = 1'b1; loadAddr = a; loadData = d;
    @(posedge clk); #1;
    loadEn = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) csrMem[i] = 32'h0;
    rst = 1'b1;
    applyStimulus(1'b1, 2'b10, 1'b1, 1'b1, 32'h100, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    dCyc = cyc;
    checkOutput("reset c1", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("reset c2", 1, 1'b0, 1'b0, 1'b1, 1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    idleInputs();
    checkOutput("idle after rst", 0, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("[TB] illegal instruction trap");
    loadCsr(12'h300, 32'h0000_0008);
    loadCsr(12'h305, 32'h0000_0200);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 32'h100, 32'hFFFF_FFFF);
    expectTrap("illegal", 32'h100, 32'd2, 32'hFFFF_FFFF, 32'h0000_1880, 32'h200);
    waitCycles(6);

    $display("[TB] back-to-back ecall trap");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 32'h40, 32'h0000_0073);
    expectTrap("ecall", 32'h40, 32'd11, 32'h0, 32'h0000_1800, 32'h200);
    waitCycles(6);

    $display("[TB] non-triggering inputs");
    applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 32'h60, 32'h0000_0013);
    checkOutput("int MIE=0", 0, 1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(1);
    applyStimulus(1'b0, 2'b10, 1'b1, 1'b1, 32'h64, 32'hFFFF_FFFF);
    checkOutput("bubble", 0, 1'b0, 1'b0, 1'b1, 1'b1);
    waitCycles(1);

    $display("[TB] vectored interrupt beats ecall");
    loadCsr(12'h300, 32'h0000_0008);
    loadCsr(12'h305, 32'h0000_0301);
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b1, 32'h80, 32'h0000_0073);
    expectTrap("interrupt", 32'h80, 32'h8000_000B, 32'h0, 32'h0000_1880, 32'h32C);
    waitCycles(6);

    $display("[TB] mret");
    loadCsr(12'h300, 32'h0000_1880);
    loadCsr(12'h341, 32'h0000_0104);
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b0, 32'h90, 32'h3020_0073);
    checkOutput("mret", 0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("mret", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("mret", 2, 1'b0, 1'b1, 1'b0, 1'b0);
    expectWrite(12'h300, 32'h0000_1888, 1);
    expectRedirect(32'h104, 2);
    waitCycles(3);

    $display("[TB] interrupt with mret in MEM");
    applyStimulus(1'b1, 2'b00, 1'b1, 1'b1, 32'hC0, 32'h3020_0073);
    expectTrap("int+mret", 32'hC0, 32'h8000_000B, 32'h0, 32'h0000_1880, 32'h32C);
    waitCycles(6);

    $display("[TB] exception with vectored mtvec uses base");
    applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 32'h44, 32'h0000_0073);
    expectTrap("exc vect", 32'h44, 32'd11, 32'h0, 32'h0000_1800, 32'h300);
    waitCycles(6);

    $display("[TB] mtvec zero fallback");
    loadCsr(12'h305, 32'h0000_0000);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 32'h500, 32'h1234_5678);
    expectTrap("fallback", 32'h500, 32'd2, 32'h1234_5678, 32'h0000_1800, FALLBACK);
    waitCycles(6);

    $display("[TB] reset during T_MCAUSE");
    loadCsr(12'h305, 32'h0000_0200);
    applyStimulus(1'b1, 2'b10, 1'b0, 1'b0, 32'h600, 32'hDEAD_BEEF);
    checkOutput("rst mid D", 0, 1'b1, 1'b1, 1'b1, 1'b0);
    checkOutput("rst mid D+1", 1, 1'b0, 1'b1, 1'b0, 1'b0);
    expectWrite(12'h341, 32'h600, 1);
    checkOutput("rst mid D+2", 2, 1'b0, 1'b0, 1'b1, 1'b1);
    for (int k = 3; k <= 8; k++) checkOutput("rst mid idle", k, 1'b0, 1'b0, 1'b1, 1'b0);
    waitCycles(2);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 7; k++) begin
      @(posedge clk); #1;
    end

    done = 1'b1;
    forever @(posedge clk);
  end

endmodule

// File: doc/trap_sequencer.md
Name: trap_sequencer

Overview:
- Multi-cycle machine-mode trap/return controller for the 5-stage RV32I pipeline.
- Samples exception, interrupt and MRET information at the MEM stage and flushes the pipeline.
- Drives the CSR file's single write port through a fixed sequence: mepc, mcause, mtval, mstatus.
- Then redirects fetch to mtvec on a trap, or to mepc on MRET.

Parameters:
- XLEN, 32, data/PC width.
- RESET_MTVEC_FALLBACK, 32'h0000_0000, redirect target used when mtvec reads as 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- valid_mem  in  1  MEM stage holds a real (non-bubble) instruction
- exp_vector_mem  in  2  {illegal_inst, ecall} of the MEM instruction
- mret_mem  in  1  MEM instruction is MRET
- pc_mem  in  XLEN  PC of the MEM instruction
- inst_mem  in  32  encoding of the MEM instruction
- ext_int  in  1  level-sensitive external interrupt request
- csr_raddr  out  12  CSR file read address; the read is combinational
- csr_rdata  in  XLEN  CSR file read data, same cycle as csr_raddr
- csr_we  out  1  CSR write enable; the write commits at the posedge
- csr_waddr  out  12  CSR write address
- csr_wdata  out  XLEN  CSR write data
- flush  out  1  kill IF..MEM and squash the MEM-stage write-back
- stall_if  out  1  freeze PC and the IF/ID register
- redirect_valid  out  1  load redirect_pc into the PC next edge
- redirect_pc  out  XLEN  new fetch address

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs are 0 (csr_raddr=0).
  - Latched pc/cause/tval are cleared.
  - A reset mid-sequence abandons it; no further CSR writes are issued.
- Trigger in IDLE (cycle D): only when valid_mem=1. Bubbles never trigger.
- Priority:
  - interrupt (ext_int & mstatus.MIE, read via csr_raddr=0x300 in IDLE) > illegal > ecall > mret.
  - Interrupt plus MRET in the same cycle: the interrupt is taken, mepc=pc_mem, and the MRET is not executed.
- Trap trigger, cycle D:
  - flush=1, stall_if=1.
  - Latch pc=pc_mem.
  - Latch cause: 32'h8000_000B for ext_int, 2 for illegal, 11 for ecall.
  - Latch tval: inst_mem for illegal, else 0.
  - Next state T_MEPC.
- T_MEPC (D+1): csr_we=1, waddr 0x341, wdata=latched pc. Next T_MCAUSE.
- T_MCAUSE (D+2): write 0x342 = cause. Next T_MTVAL.
- T_MTVAL (D+3): write 0x343 = tval. Next T_MSTATUS.
- T_MSTATUS (D+4):
  - raddr 0x300; write 0x300 = rdata with MPIE(bit 7)=MIE(bit 3), MIE=0, MPP(bits 12:11)=2'b11.
  - Next T_JUMP.
- T_JUMP (D+5):
  - raddr 0x305; redirect_valid=1.
  - If mtvec[1:0]=01 and cause is an interrupt: redirect_pc = {mtvec[31:2],2'b00} + 4*cause[30:0]. Otherwise: {mtvec[31:2],2'b00}.
  - If that result is 0, use RESET_MTVEC_FALLBACK.
  - Next IDLE.
- MRET trigger (D): flush=1, stall_if=1. Next M_STATUS.
- M_STATUS (D+1): raddr 0x300; write 0x300 with MIE=MPIE, MPIE=1, MPP=2'b11. Next M_JUMP.
- M_JUMP (D+2): raddr 0x341; redirect_valid=1, redirect_pc = {rdata[31:2],2'b00}. Next IDLE.
- Hold and timing rules:
  - stall_if=1 in every non-IDLE state. flush is asserted in the trigger cycle only.
  - All triggers are ignored outside IDLE. ext_int is not latched; it is re-sampled in IDLE.
  - The cycle after a redirect is IDLE and may trigger again (back-to-back traps allowed).
- Latency: trap redirect D+5 (6 cycles stalled); MRET redirect D+2.
- csr_we is never asserted in IDLE or in the trigger cycle.

Decomposition:
- Package trap_defs:
  - CSR addresses (MSTATUS 0x300, MTVEC 0x305, MEPC 0x341, MCAUSE 0x342, MTVAL 0x343).
  - Cause codes.
  - mstatus bit positions (MIE 3, MPIE 7, MPP 12:11).
  - State enum.
- One sub-module, trap_cause_enc: combinational priority encoder producing take_trap, take_mret, cause, tval.

Test Plan:
- Illegal inst 32'hFFFF_FFFF, pc 0x100, mtvec 0x200, mstatus 0x8:
  - csr writes 0x341=0x100, 0x342=2, 0x343=0xFFFFFFFF, 0x300=0x1880 on D+1..D+4.
  - redirect_pc 0x200 at D+5.
- ECALL at pc 0x40 with ext_int=0 -> mcause 11, mtval 0, flush only at D, stall_if high for D..D+5.
- ext_int=1, MIE=1, vectored mtvec 0x301, with ECALL in MEM -> interrupt wins: mcause 0x8000000B, redirect_pc 0x32C.
- ext_int=1 with MIE=0, or valid_mem=0 -> no trigger, all outputs 0.
- MRET with mstatus 0x1880, mepc 0x104 -> write 0x300=0x1888 at D+1, redirect 0x104 at D+2.
- rst asserted at T_MCAUSE -> next cycle state IDLE, csr_we=0, no mtval/mstatus write, redirect_valid never asserted.
